// File: rtl/jam.sv
// jam: exhaustive 8x8 job-assignment search reporting the minimum total cost and the number of optimal assignments.
// Define JAM_TABLE_CACHE_EN to preload the cost ROM into a register table and evaluate one permutation per cycle.
module jam (
  input  logic       CLK,
  input  logic       RST,
  output logic [2:0] W,
  output logic [2:0] J,
  input  logic [6:0] Cost,
  output logic [3:0] MatchCount,
  output logic [9:0] MinCost,
  output logic       Valid
);

  logic [2:0] perm_reg  [8];
  logic [2:0] perm_sw   [8];
  logic [2:0] perm_next [8];
  logic [2:0] piv_i;
  logic [2:0] piv_j;
  logic       piv_found;
  logic [2:0] w_reg;
  logic [2:0] j_reg;
  logic [9:0] min_reg;
  logic [3:0] match_reg;
  logic [9:0] total;
  logic       cmp_en;

  // Lexicographic successor: pivot, swap partner, then the suffix is reversed below.
  always_comb begin
    piv_i     = '0;
    piv_found = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (perm_reg[k] < perm_reg[k+1]) begin
        piv_i     = 3'(k);
        piv_found = 1'b1;
      end
    end
    piv_j = piv_i;
    for (int k = 1; k < 8; k++) begin
      if (3'(k) > piv_i && perm_reg[k] > perm_reg[piv_i])
        piv_j = 3'(k);
    end
    perm_sw        = perm_reg;
    perm_sw[piv_i] = perm_reg[piv_j];
    perm_sw[piv_j] = perm_reg[piv_i];
  end

  // Position gi > piv_i takes element (piv_i + 8 - gi), i.e. piv_i - gi modulo 8.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rev
      assign perm_next[gi] = (3'(gi) > piv_i) ? perm_sw[piv_i - 3'(gi)] : perm_sw[gi];
    end
  endgenerate

`ifdef JAM_TABLE_CACHE_EN

  typedef enum logic [1:0] {S_LOAD, S_EVAL, S_DONE, S_HOLD} state_t;
  state_t state_reg, state_next;

  logic [6:0] load_cnt_reg;
  logic [6:0] table_reg [64];

  always_comb begin
    total = '0;
    for (int k = 0; k < 8; k++)
      total = total + {3'b000, table_reg[{3'(k), perm_reg[k]}]};
  end

  assign cmp_en = (state_reg == S_EVAL);

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= S_LOAD;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_LOAD:  if (load_cnt_reg == 7'd64) state_next = S_EVAL;
      S_EVAL:  if (!piv_found) state_next = S_DONE;
      S_DONE:  state_next = S_HOLD;
      default: state_next = S_HOLD;
    endcase
  end

  always_comb begin
    Valid = (state_reg == S_DONE);
  end

  // Cost for the address driven in cycle c arrives in cycle c+1, so the store lags the address by one.
  always_ff @(posedge CLK) begin
    if (state_reg == S_LOAD && load_cnt_reg != 7'd0)
      table_reg[6'(load_cnt_reg - 7'd1)] <= Cost;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      w_reg        <= '0;
      j_reg        <= '0;
      load_cnt_reg <= '0;
      for (int k = 0; k < 8; k++) perm_reg[k] <= 3'(k);
    end else begin
      case (state_reg)
        S_LOAD: begin
          load_cnt_reg <= load_cnt_reg + 7'd1;
          if ({w_reg, j_reg} != 6'h3F)
            {w_reg, j_reg} <= {w_reg, j_reg} + 6'd1;
        end
        S_EVAL: begin
          if (piv_found) perm_reg <= perm_next;
        end
        default: ;
      endcase
    end
  end

`else

  typedef enum logic [2:0] {S_FETCH, S_SUM, S_NEXT, S_DONE, S_HOLD} state_t;
  state_t state_reg, state_next;

  logic [9:0] acc_reg;

  // In SUM the bus carries the cost of the eighth address, completing the total.
  assign total  = acc_reg + {3'b000, Cost};
  assign cmp_en = (state_reg == S_SUM);

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH: if (w_reg == 3'd7) state_next = S_SUM;
      S_SUM:   state_next = S_NEXT;
      S_NEXT:  state_next = piv_found ? S_FETCH : S_DONE;
      S_DONE:  state_next = S_HOLD;
      default: state_next = S_HOLD;
    endcase
  end

  always_comb begin
    Valid = (state_reg == S_DONE);
  end

  // While W=k is on the bus, Cost holds the entry for W=k-1 (stale when k=0, so the accumulator clears).
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_reg   <= '0;
      j_reg   <= '0;
      acc_reg <= '0;
      for (int k = 0; k < 8; k++) perm_reg[k] <= 3'(k);
    end else begin
      case (state_reg)
        S_FETCH: begin
          acc_reg <= (w_reg == 3'd0) ? 10'd0 : acc_reg + {3'b000, Cost};
          if (w_reg != 3'd7) begin
            w_reg <= w_reg + 3'd1;
            j_reg <= perm_reg[w_reg + 3'd1];
          end
        end
        S_NEXT: begin
          if (piv_found) begin
            perm_reg <= perm_next;
            w_reg    <= '0;
            j_reg    <= perm_next[0];
          end
        end
        default: ;
      endcase
    end
  end

`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      min_reg   <= 10'h3FF;
      match_reg <= '0;
    end else if (cmp_en) begin
      if (total < min_reg) begin
        min_reg   <= total;
        match_reg <= 4'd1;
      end else if (total == min_reg && match_reg != 4'd15) begin
        match_reg <= match_reg + 4'd1;
      end
    end
  end

  assign W          = w_reg;
  assign J          = j_reg;
  assign MinCost    = min_reg;
  assign MatchCount = match_reg;

endmodule

// File: tb/tb_jam.sv
// tb_jam: table-driven and randomized checks of jam against an enumeration model that decodes
// every permutation index in the factorial number system.
`timescale 1ns/1ps
module tb_jam;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic [3:0] MatchCount;
  logic [9:0] MinCost;
  logic       Valid;

  logic [6:0] rom [64];
  int n_checks = 0;
  int n_fail   = 0;

`ifdef JAM_TABLE_CACHE_EN
  localparam int BUDGET = 40600;
`else
  localparam int BUDGET = 450000;
`endif

  typedef struct {
    logic [63:0][6:0] cost;
    int               exp_min;
    int               exp_cnt;
  } vec_t;

  vec_t vecs [6];

  always #5 CLK = ~CLK;

  jam dut (
    .CLK(CLK), .RST(RST), .W(W), .J(J), .Cost(Cost),
    .MatchCount(MatchCount), .MinCost(MinCost), .Valid(Valid)
  );

  // External ROM with one-cycle registered read
  always_ff @(posedge CLK) Cost <= rom[{W, J}];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [63:0][6:0] c, output int mn, output int cnt);
    int fact [8];
    int avail [8];
    int r, s, d;
    fact = '{5040, 720, 120, 24, 6, 2, 1, 1};
    mn  = 1 << 20;
    cnt = 0;
    for (int n = 0; n < 40320; n++) begin
      for (int k = 0; k < 8; k++) avail[k] = k;
      r = n;
      s = 0;
      for (int pos = 0; pos < 8; pos++) begin
        d = r / fact[pos];
        r = r % fact[pos];
        s += int'(c[pos*8 + avail[d]]);
        for (int k = d; k < 7; k++) avail[k] = avail[k+1];
      end
      if (s < mn) begin
        mn  = s;
        cnt = 1;
      end else if (s == mn) begin
        cnt++;
      end
    end
    if (cnt > 15) cnt = 15;
  endfunction

  // Pulses reset, checks reset outputs, releases it and checks the first fetch addresses.
  task automatic do_reset(input string tag);
    int na;
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check({tag, " rst_W"}, W, 0);
    check({tag, " rst_J"}, J, 0);
    check({tag, " rst_MinCost"}, MinCost, 10'h3FF);
    check({tag, " rst_MatchCount"}, MatchCount, 0);
    check({tag, " rst_Valid"}, Valid, 0);
    RST = 1'b0;
`ifdef JAM_TABLE_CACHE_EN
    na = 64;
`else
    na = 8;
`endif
    for (int c = 0; c < na; c++) begin
`ifdef JAM_TABLE_CACHE_EN
      check($sformatf("%s addr%0d", tag, c), {W, J}, c);
`else
      check($sformatf("%s W%0d", tag, c), W, c);
      check($sformatf("%s J%0d", tag, c), J, c);
`endif
      @(negedge CLK);
    end
  endtask

  task automatic run(input int id, input logic [63:0][6:0] c, input int exp_min, input int exp_cnt);
    string tag;
    int cyc, high;
    logic [2:0] w_hold, j_hold;
    tag = $sformatf("table%0d", id);
    for (int k = 0; k < 64; k++) rom[k] = c[k];
    do_reset(tag);
`ifdef JAM_TABLE_CACHE_EN
    cyc = 64;
`else
    cyc = 8;
`endif
    while (!Valid && cyc < BUDGET) begin
      @(negedge CLK);
      cyc++;
    end
    check({tag, " valid_within_budget"}, int'(Valid), 1);
    if (Valid) begin
      check({tag, " not_early"}, int'(cyc >= 40320), 1);
      check({tag, " MinCost"}, MinCost, exp_min);
      check({tag, " MatchCount"}, MatchCount, exp_cnt);
      w_hold = W;
      j_hold = J;
`ifdef JAM_TABLE_CACHE_EN
      check({tag, " W_final"}, W, 7);
      check({tag, " J_final"}, J, 7);
`endif
      high = 1;
      repeat (16) begin
        @(negedge CLK);
        if (Valid) high++;
      end
      check({tag, " valid_width"}, high, 1);
      check({tag, " MinCost_hold"}, MinCost, exp_min);
      check({tag, " MatchCount_hold"}, MatchCount, exp_cnt);
      check({tag, " W_hold"}, W, w_hold);
      check({tag, " J_hold"}, J, j_hold);
    end
    $display("run %s: MinCost=%0d MatchCount=%0d expected %0d/%0d after %0d cycles",
             tag, MinCost, MatchCount, exp_min, exp_cnt, cyc);
  endtask

  initial begin
    int mn, cnt, high;
    for (int k = 0; k < 64; k++) rom[k] = '0;

    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < 8; j++) begin
        vecs[0].cost[w*8+j] = (w == j) ? 7'd0 : 7'd10;
        vecs[1].cost[w*8+j] = 7'(j);
        vecs[2].cost[w*8+j] = (w == j || (w < 2 && j < 2)) ? 7'd1 : 7'd50;
        vecs[3].cost[w*8+j] = 7'd127;
        vecs[4].cost[w*8+j] = 7'($urandom_range(0, 3));
        vecs[5].cost[w*8+j] = 7'($urandom_range(0, 127));
      end
    end
    vecs[0].exp_min = 0;    vecs[0].exp_cnt = 1;
    vecs[1].exp_min = 28;   vecs[1].exp_cnt = 15;
    vecs[2].exp_min = 8;    vecs[2].exp_cnt = 2;
    vecs[3].exp_min = 1016; vecs[3].exp_cnt = 15;
    for (int v = 4; v < 6; v++) begin
      model(vecs[v].cost, mn, cnt);
      vecs[v].exp_min = mn;
      vecs[v].exp_cnt = cnt;
    end

    for (int v = 0; v < 6; v++)
      run(v, vecs[v].cost, vecs[v].exp_min, vecs[v].exp_cnt);

    // Abort a run partway, then restart on a different table
    for (int k = 0; k < 64; k++) rom[k] = vecs[0].cost[k];
    do_reset("midrun");
    high = 0;
    repeat (20000) begin
      @(negedge CLK);
      if (Valid) high++;
    end
    check("midrun valid_quiet", high, 0);
    run(6, vecs[2].cost, 8, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
